// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the ram01 port arbiter.
package ram_arb_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LD  = 1'b1
   } owner_t;

   localparam int AW_DEF   = 12;
   localparam int DW_DEF   = 16;
   localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the loader has been denied.
module arb_starve_cnt
   import ram_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                clr,
   output logic [STARVE_W-1:0] cnt,
   output logic                at_limit
);

   localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] cnt_q;
   logic [STARVE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT_V)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt      = cnt_q;
   assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares single-port ram01 between the CPU (fixed priority) and the loader,
// with a starvation counter guaranteeing the loader a slot.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,
   output logic          ram_wren,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_data,
   input  logic [DW-1:0] ram_q,
   output logic          cpu_stall
);

   logic                at_limit;
   logic [STARVE_W-1:0] starve_cnt;
   logic                cpu_win;
   logic                ld_win;
   logic                rsp_valid_q;
   logic                rsp_valid_d;
   owner_t              rsp_owner_q;
   owner_t              rsp_owner_d;

   arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (1'b1),
      .clr      (ld_gnt | ~ld_req),
      .cnt      (starve_cnt),
      .at_limit (at_limit)
   );

   // Grants are forced low while reset is asserted, which also parks the RAM mux.
   always_comb begin
      cpu_win   = cpu_req & (~ld_req | ~at_limit);
      ld_win    = ld_req & (~cpu_req | at_limit);
      cpu_gnt   = cpu_win & rst;
      ld_gnt    = ld_win & rst;
      cpu_stall = cpu_req & ~cpu_gnt;
   end

   always_comb begin
      ram_wren    = 1'b0;
      ram_address = '0;
      ram_data    = '0;
      if (cpu_gnt) begin
         ram_wren    = cpu_we;
         ram_address = cpu_addr;
         ram_data    = cpu_wdata;
      end else if (ld_gnt) begin
         ram_wren    = ld_we;
         ram_address = ld_addr;
         ram_data    = ld_wdata;
      end
   end

   // ram01 returns q one cycle after the address, so one response slot suffices.
   always_comb begin
      rsp_valid_d = (cpu_gnt & ~cpu_we) | (ld_gnt & ~ld_we);
      rsp_owner_d = rsp_owner_q;
      if (cpu_gnt && !cpu_we) begin
         rsp_owner_d = OWN_CPU;
      end else if (ld_gnt && !ld_we) begin
         rsp_owner_d = OWN_LD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= OWN_CPU;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_owner_q <= rsp_owner_d;
      end
   end

   assign cpu_rvalid = rst & rsp_valid_q & (rsp_owner_q == OWN_CPU);
   assign ld_rvalid  = rst & rsp_valid_q & (rsp_owner_q == OWN_LD);
   assign cpu_rdata  = ram_q;
   assign ld_rdata   = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a ram01 model and a response scoreboard.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, ld_req, ld_we;
   logic [11:0] cpu_addr, ld_addr, ram_address;
   logic [15:0] cpu_wdata, ld_wdata, cpu_rdata, ld_rdata, ram_data, ram_q;
   logic        cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid, ram_wren, cpu_stall;
   logic        preload;

   typedef struct packed {
      logic        owner;
      logic [15:0] data;
   } rsp_t;

   rsp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.AW(12), .DW(16), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
      .ram_q(ram_q), .cpu_stall(cpu_stall)
   );

   // ram01 model: registered read, write on wren
   logic [15:0] mem [0:4095];
   always @(posedge clk) begin
      if (preload) begin
         mem[12'h010] <= 16'hBEEF;
         mem[12'h001] <= 16'h1111;
         mem[12'h002] <= 16'h2222;
      end else if (ram_wren) begin
         mem[ram_address] <= ram_data;
      end
      ram_q <= mem[ram_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response is presented.
   always @(negedge clk) begin
      rsp_t e;
      if (cpu_rvalid || ld_rvalid) begin
         chk("rvalid_exclusive", 32'(cpu_rvalid & ld_rvalid), 32'd0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid cpu_rvalid=%b ld_rvalid=%b expected none", cpu_rvalid, ld_rvalid);
         end else begin
            e = sb.pop_front();
            chk("rsp_owner", 32'(ld_rvalid), 32'(e.owner));
            chk("rsp_data", 32'(ld_rvalid ? ld_rdata : cpu_rdata), 32'(e.data));
         end
      end
   end

   // Called just after a rising edge; returns just after the next one.
   task automatic cyc(input logic c_req, input logic c_we, input logic [11:0] c_addr,
                      input logic [15:0] c_wd, input logic l_req, input logic l_we,
                      input logic [11:0] l_addr, input logic [15:0] l_wd,
                      input logic e_cg, input logic e_lg, input logic e_wren,
                      input logic [11:0] e_addr, input logic [15:0] e_data,
                      input logic e_rsp, input logic [15:0] e_rd);
      rsp_t e;
      cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      ld_req  = l_req; ld_we  = l_we; ld_addr  = l_addr; ld_wdata  = l_wd;
      @(negedge clk);
      chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
      chk("ld_gnt", 32'(ld_gnt), 32'(e_lg));
      chk("cpu_stall", 32'(cpu_stall), 32'(c_req & ~e_cg));
      chk("ram_wren", 32'(ram_wren), 32'(e_wren));
      chk("ram_address", 32'(ram_address), 32'(e_addr));
      chk("ram_data", 32'(ram_data), 32'(e_data));
      if (e_rsp) begin
         e.owner = e_lg;
         e.data  = e_rd;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
          1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000);
   endtask

   task automatic starve_run(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b1, 12'h100, 16'hAAAA, 1'b1, 1'b1, 12'h101, 16'h5555,
             (i % 5) != 4, (i % 5) == 4, 1'b1,
             ((i % 5) == 4) ? 12'h101 : 12'h100,
             ((i % 5) == 4) ? 16'h5555 : 16'hAAAA, 1'b0, 16'h0000);
         chk("starve_cnt", 32'(dut.starve_cnt), 32'((i + 1) % 5));
      end
   endtask

   initial begin
      rst = 1'b0; preload = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; cpu_wdata = 16'h0000;
      ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 12'h002; ld_wdata  = 16'h0000;
      repeat (3) @(posedge clk);
      #1 preload = 1'b0;
      @(negedge clk);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
      chk("rst_ram_wren", 32'(ram_wren), 32'd0);
      chk("rst_ram_address", 32'(ram_address), 32'd0);
      chk("rst_rvalid", 32'({cpu_rvalid, ld_rvalid}), 32'd0);
      chk("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // release: CPU wins same cycle, reads BEEF; loader then reads 0x002
      cyc(1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000,
          1'b1, 1'b0, 1'b0, 12'h010, 16'h0000, 1'b1, 16'hBEEF);
      cyc(1'b0, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000,
          1'b0, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b1, 16'h2222);
      idle();

      // loader write, then CPU read-back
      cyc(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h0FF, 16'h1234,
          1'b0, 1'b1, 1'b1, 12'h0FF, 16'h1234, 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 12'h0FF, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
          1'b1, 1'b0, 1'b0, 12'h0FF, 16'h0000, 1'b1, 16'h1234);
      idle();

      // back-to-back reads from different owners
      cyc(1'b1, 1'b0, 12'h001, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
          1'b1, 1'b0, 1'b0, 12'h001, 16'h0000, 1'b1, 16'h1111);
      cyc(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000,
          1'b0, 1'b1, 1'b0, 12'h002, 16'h0000, 1'b1, 16'h2222);
      idle();
      idle();

      // continuous contention: period-5 pattern
      starve_run(10);
      idle();

      // reset in the cycle after a granted CPU read
      cyc(1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000,
          1'b1, 1'b0, 1'b0, 12'h010, 16'h0000, 1'b0, 16'h0000);
      rst = 1'b0;
      cpu_req = 1'b0; ld_req = 1'b0;
      @(negedge clk);
      chk("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("midrst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("post_rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
      @(posedge clk);
      #1;
      idle();
      starve_run(5);
      idle();
      idle();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
